pixel_stream_tx: RTL and testbench

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

---
 rtl/pixel_stream_tx.sv | 121 ++++++++++++
 tb/tb_pixel_stream_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_tx.sv
// Streams one frame of DEPTH lattice pixels from a 9-port BRAM read interface onto AXI-Stream.
// Reads are credit-limited into a 3-entry output FIFO so back-pressure never loses or repeats a pixel.
module pixel_stream_tx #(
  parameter int DATA_WIDTH             = 16,
  parameter int DEPTH                  = 2500,
  parameter int ADDRESS_WIDTH          = 12,
  parameter int C_M00_AXIS_TDATA_WIDTH = 144
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  input  logic                                start,
  output logic [ADDRESS_WIDTH-1:0]            rd_addr,
  output logic                                rd_en,
  input  logic [DATA_WIDTH-1:0]               rd_n,
  input  logic [DATA_WIDTH-1:0]               rd_null,
  input  logic [DATA_WIDTH-1:0]               rd_ne,
  input  logic [DATA_WIDTH-1:0]               rd_e,
  input  logic [DATA_WIDTH-1:0]               rd_se,
  input  logic [DATA_WIDTH-1:0]               rd_s,
  input  logic [DATA_WIDTH-1:0]               rd_sw,
  input  logic [DATA_WIDTH-1:0]               rd_w,
  input  logic [DATA_WIDTH-1:0]               rd_nw,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic                                busy,
  output logic                                done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = C_M00_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_last_q, rd_last_d;
  logic              vld_q, vld_last_q;
  logic [TW-1:0]     mem_q [3];
  logic [2:0]        last_q;
  logic [1:0]        wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic              push, pop;
  logic [9*DATA_WIDTH-1:0] pix;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign pix  = {rd_nw, rd_w, rd_sw, rd_s, rd_se, rd_e, rd_ne, rd_null, rd_n};
  assign push = vld_q;
  assign pop  = m00_axis_tvalid & m00_axis_tready;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    rd_last_d = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (pop && last_q[rd_ptr_q]) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    // Credit check: entries after this edge plus the read still at the BRAM must leave a free slot.
    if (state_d == S_STREAM && issued_q < CW'(DEPTH) &&
        ({1'b0, count_d} + {2'b0, rd_en_q}) <= 3'd2) begin
      rd_en_d   = 1'b1;
      addr_d    = ADDRESS_WIDTH'(issued_q);
      issued_d  = issued_q + 1'b1;
      rd_last_d = (issued_q == CW'(DEPTH - 1));
    end
    if (state_d == S_IDLE) issued_d = '0;
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      vld_q      <= 1'b0;
      vld_last_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      rd_last_q  <= rd_last_d;
      vld_q      <= rd_en_q;
      vld_last_q <= rd_last_q;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q]  <= TW'(pix);
        last_q[wr_ptr_q] <= vld_last_q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  assign rd_addr         = addr_q;
  assign rd_en           = rd_en_q;
  assign m00_axis_tvalid = (count_q != 2'd0);
  assign m00_axis_tdata  = m00_axis_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m00_axis_tstrb  = {(TW/8){m00_axis_tvalid}};
  assign m00_axis_tlast  = m00_axis_tvalid & last_q[rd_ptr_q];
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Scoreboard bench for pixel_stream_tx: expected pixels are queued at frame start and popped by a monitor.
// A second instance with DEPTH=1 covers the single-pixel frame.
module tb_pixel_stream_tx;
  localparam int DW = 16, DEPTH = 2500, AW = 12, TW = 144;

  logic clk = 1'b0, rst_n;
  logic start, start1;
  logic [AW-1:0] rd_addr, rd_addr1;
  logic rd_en, rd_en1;
  logic [DW-1:0] b0n, b0null, b0ne, b0e, b0se, b0s, b0sw, b0w, b0nw;
  logic [DW-1:0] b1n, b1null, b1ne, b1e, b1se, b1s, b1sw, b1w, b1nw;
  logic tvalid, tlast, tready, busy, done;
  logic tvalid1, tlast1, tready1, busy1, done1;
  logic [TW-1:0] tdata, tdata1;
  logic [TW/8-1:0] tstrb, tstrb1;

  int n_checks = 0, n_fail = 0;
  int sb[$];
  int beat_total = 0, reads_total = 0, rd_exp = 0;
  time last_beat_t = 0;
  bit exp_done = 0, stall_prev = 0;
  logic [TW-1:0] stall_data;

  always #5 clk = ~clk;

  pixel_stream_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .C_M00_AXIS_TDATA_WIDTH(TW)) u_dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_n(b0n), .rd_null(b0null), .rd_ne(b0ne), .rd_e(b0e), .rd_se(b0se),
    .rd_s(b0s), .rd_sw(b0sw), .rd_w(b0w), .rd_nw(b0nw),
    .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast), .m00_axis_tready(tready), .busy(busy), .done(done));

  pixel_stream_tx #(.DATA_WIDTH(DW), .DEPTH(1), .ADDRESS_WIDTH(AW), .C_M00_AXIS_TDATA_WIDTH(TW)) u_one (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start1),
    .rd_addr(rd_addr1), .rd_en(rd_en1),
    .rd_n(b1n), .rd_null(b1null), .rd_ne(b1ne), .rd_e(b1e), .rd_se(b1se),
    .rd_s(b1s), .rd_sw(b1sw), .rd_w(b1w), .rd_nw(b1nw),
    .m00_axis_tvalid(tvalid1), .m00_axis_tdata(tdata1), .m00_axis_tstrb(tstrb1),
    .m00_axis_tlast(tlast1), .m00_axis_tready(tready1), .busy(busy1), .done(done1));

  // Direction d of pixel a; every word in a frame is distinct so swaps and repeats show up.
  function automatic logic [DW-1:0] word(input int a, input int d);
    return DW'((a * 9 + d) ^ 32'h5A3C);
  endfunction

  // Expected packing: n lowest, then null, ne, e, se, s, sw, w, nw.
  function automatic logic [TW-1:0] pix(input int a);
    logic [TW-1:0] v;
    v = '0;
    for (int d = 0; d < 9; d++) v[d*DW +: DW] = word(a, d);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      b0n <= word(int'(rd_addr), 0); b0null <= word(int'(rd_addr), 1); b0ne <= word(int'(rd_addr), 2);
      b0e <= word(int'(rd_addr), 3); b0se   <= word(int'(rd_addr), 4); b0s  <= word(int'(rd_addr), 5);
      b0sw <= word(int'(rd_addr), 6); b0w   <= word(int'(rd_addr), 7); b0nw <= word(int'(rd_addr), 8);
    end
    if (rd_en1) begin
      b1n <= word(int'(rd_addr1), 0); b1null <= word(int'(rd_addr1), 1); b1ne <= word(int'(rd_addr1), 2);
      b1e <= word(int'(rd_addr1), 3); b1se   <= word(int'(rd_addr1), 4); b1s  <= word(int'(rd_addr1), 5);
      b1sw <= word(int'(rd_addr1), 6); b1w   <= word(int'(rd_addr1), 7); b1nw <= word(int'(rd_addr1), 8);
    end
  end

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done   = 0;
      stall_prev = 0;
      rd_exp     = 0;
    end else begin
      chk("done_pulse", TW'(done), TW'(exp_done));
      exp_done = 0;
      if (done) rd_exp = 0;
      if (tvalid) chk("tstrb", TW'(tstrb), TW'({(TW/8){1'b1}}));
      if (stall_prev) begin
        chk("stall_valid", TW'(tvalid), TW'(1));
        chk("stall_data", tdata, stall_data);
      end
      if (rd_en) begin
        chk("rd_addr", TW'(rd_addr), TW'(rd_exp));
        rd_exp++;
        reads_total++;
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", TW'(1), TW'(0));
        end else begin
          int idx;
          idx = sb.pop_front();
          chk("beat_data", tdata, pix(idx));
          chk("beat_tlast", TW'(tlast), TW'(idx == DEPTH - 1));
          if (idx == DEPTH - 1) exp_done = 1;
        end
        beat_total++;
        last_beat_t = $time;
      end
      stall_prev = tvalid && !tready;
      stall_data = tdata;
    end
  end

  task automatic go();
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < DEPTH; i++) sb.push_back(i);
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs until done, or until stop_beats beats of this frame have passed (stop_beats > 0).
  task automatic run(input bit rnd, input int b0, input int stop_beats);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (n < 20000 && !hit) begin
      @(posedge clk); #1;
      if (rnd) tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stop_beats > 0) hit = (beat_total - b0 >= stop_beats);
      else hit = done;
      n++;
    end
    if (!hit) chk("run_timeout", TW'(0), TW'(1));
  endtask

  task automatic chk_reset();
    chk("rst_rd_addr", TW'(rd_addr), '0);
    chk("rst_rd_en", TW'(rd_en), '0);
    chk("rst_tvalid", TW'(tvalid), '0);
    chk("rst_tlast", TW'(tlast), '0);
    chk("rst_tdata", tdata, '0);
    chk("rst_tstrb", TW'(tstrb), '0);
    chk("rst_busy", TW'(busy), '0);
    chk("rst_done", TW'(done), '0);
  endtask

  initial begin
    int b0, r0, nb, bt, dt;
    time first_t;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; tready = 1'b0; tready1 = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // Full-rate frame: latency, throughput, done timing.
    tready = 1'b1;
    b0 = beat_total;
    go();
    @(negedge clk);
    chk("lat_rd_en_e0", TW'(rd_en), TW'(1));
    chk("lat_tvalid_e0", TW'(tvalid), TW'(0));
    chk("busy_stream", TW'(busy), TW'(1));
    @(negedge clk);
    chk("lat_tvalid_e1", TW'(tvalid), TW'(0));
    @(negedge clk);
    chk("lat_tvalid_e2", TW'(tvalid), TW'(1));
    first_t = $time;
    run(1'b0, b0, 0);
    chk("frame1_beats", TW'(beat_total - b0), TW'(DEPTH));
    chk("frame1_cycles", TW'((last_beat_t - first_t) / 10), TW'(DEPTH - 1));
    chk("frame1_sb_empty", TW'(sb.size()), '0);
    @(negedge clk);
    chk("idle_after_done", TW'(busy), TW'(0));

    // Held-off start then random back-pressure.
    tready = 1'b0;
    b0 = beat_total; r0 = reads_total;
    go();
    repeat (20) @(negedge clk);
    chk("stall_reads", TW'(reads_total - r0), TW'(3));
    chk("stall_head_valid", TW'(tvalid), TW'(1));
    chk("stall_head_pix0", tdata, pix(0));
    run(1'b1, b0, 0);
    chk("frame2_beats", TW'(beat_total - b0), TW'(DEPTH));
    chk("frame2_sb_empty", TW'(sb.size()), '0);

    // start re-pulsed during the frame must be ignored.
    tready = 1'b1;
    @(negedge clk);
    b0 = beat_total;
    go();
    repeat (5) @(posedge clk);
    #1 start = 1'b1; @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1 start = 1'b1; @(posedge clk); #1 start = 1'b0;
    run(1'b0, b0, 0);
    repeat (10) @(negedge clk);
    chk("repulse_beats", TW'(beat_total - b0), TW'(DEPTH));
    chk("repulse_idle", TW'(busy), TW'(0));

    // Reset mid-frame, then a clean frame from pixel 0.
    b0 = beat_total;
    go();
    run(1'b1, b0, 1000);
    @(posedge clk); #1 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset();
    repeat (3) @(negedge clk);
    chk_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", TW'(busy), TW'(0));
    tready = 1'b1;
    b0 = beat_total;
    go();
    run(1'b0, b0, 0);
    chk("restart_beats", TW'(beat_total - b0), TW'(DEPTH));
    chk("restart_sb_empty", TW'(sb.size()), '0);

    // Single-pixel frame.
    nb = 0; bt = -10; dt = -10;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tvalid1 && tready1) begin
        nb++; bt = i;
        chk("one_tlast", TW'(tlast1), TW'(1));
        chk("one_data", tdata1, pix(0));
      end
      if (done1) dt = i;
    end
    chk("one_beats", TW'(nb), TW'(1));
    chk("one_done_next", TW'(dt), TW'(bt + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
